// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
// Single-port board RAM arbiter. Each cycle it grants at most one of: a clear-sweep
// write, a display cell read, or a game-logic cell write. Write starvation is bounded
// by STARVE_LIMIT. Arbitration happens in cycle N, the RAM controls are registered
// into N+1, and read data returns in N+2.
// Optional feature: define BOARD_CLEAR_EN to build the CLEAR state and the
// clr_req/clr_busy/clr_done sweep. Without it, clr_busy and clr_done are tied low
// and clr_req is ignored.
module board_mem_arbiter #(
    parameter int CELLS        = 100,
    parameter int STARVE_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_req,
    input  logic [6:0] disp_addr,
    output logic       disp_gnt,
    output logic       disp_rvalid,
    output logic [1:0] disp_data,
    input  logic       wr_req,
    input  logic [6:0] wr_addr,
    input  logic [1:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    output logic [6:0] mem_addr,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata,
    input  logic       clr_req,
    output logic       clr_busy,
    output logic       clr_done
);

    localparam logic [6:0] NUM_CELLS  = 7'(CELLS);
    localparam logic [4:0] STARVE_MAX = 5'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN
`ifdef BOARD_CLEAR_EN
        , S_CLEAR
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] starve_q, starve_d;
    logic       wr_pend;
    logic       starved;
    logic       clr_win;
    logic       grant_rd;
    logic       grant_wr;
    logic       disp_in_range;
    logic       wr_in_range;
    logic       mem_we_d;
    logic [6:0] mem_addr_d;
    logic [1:0] mem_wdata_d;
    logic       rd_oor_q;
    logic       rvalid_oor_q;

`ifdef BOARD_CLEAR_EN
    logic [6:0] clr_cnt_q;
    logic       grant_clr;

    assign clr_win = clr_req;
`else
    logic unused_clr_req;

    assign unused_clr_req = clr_req;
    assign clr_win        = 1'b0;
    assign clr_busy       = 1'b0;
    assign clr_done       = 1'b0;
`endif

    assign disp_in_range = (disp_addr < NUM_CELLS);
    assign wr_in_range   = (wr_addr < NUM_CELLS);
    // The write whose wr_ack is high this cycle is already done; the held wr_req
    // must not be arbitrated again.
    assign wr_pend       = wr_req && !wr_ack;
    assign starved       = wr_pend && (starve_q == STARVE_MAX);

    // State register; reset is sampled synchronously on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
        end else begin
            // NOTE: sequential state is assigned with <= so every register samples
            // pre-edge values; the combinational block below uses = instead.
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next state, arbitration decision and next RAM controls for this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a variable unassigned and infer a latch.
        state_d     = state_q;
        starve_d    = starve_q;
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
`ifdef BOARD_CLEAR_EN
        grant_clr   = 1'b0;
`endif

        case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                if (clr_win) begin
                    // Clear takes the whole cycle; a pending write stays pending.
`ifdef BOARD_CLEAR_EN
                    state_d = S_CLEAR;
`endif
                end else if (starved) begin
                    grant_wr = 1'b1;
                end else if (disp_req) begin
                    grant_rd = 1'b1;
                end else if (wr_pend) begin
                    grant_wr = 1'b1;
                end
            end
`ifdef BOARD_CLEAR_EN
            S_CLEAR: begin
                // clr_cnt_q == NUM_CELLS is the cycle the last sweep write is on
                // the RAM bus; nothing new is granted until RUN resumes.
                if (clr_cnt_q == NUM_CELLS) begin
                    state_d = S_RUN;
                end else begin
                    grant_clr   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = clr_cnt_q;
                    mem_wdata_d = 2'b00;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Out-of-range accesses are acknowledged but never reach the RAM.
        if (grant_wr && wr_in_range) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end else if (grant_rd && disp_in_range) begin
            mem_addr_d  = disp_addr;
        end

        // Only RUN arbitration cycles age a waiting write, so CLEAR freezes it.
        if (wr_ack) begin
            starve_d = '0;
        end else if ((state_q == S_RUN) && wr_pend && !grant_wr && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 5'd1;
        end
    end

    // Registered RAM controls, grants, acks and the two-stage read return pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_gnt     <= 1'b0;
            disp_rvalid  <= 1'b0;
            rd_oor_q     <= 1'b0;
            rvalid_oor_q <= 1'b0;
            wr_ack       <= 1'b0;
            wr_err       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            disp_gnt     <= grant_rd;
            rd_oor_q     <= grant_rd && !disp_in_range;
            disp_rvalid  <= disp_gnt;
            rvalid_oor_q <= rd_oor_q;
            wr_ack       <= grant_wr;
            wr_err       <= grant_wr && !wr_in_range;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
        end
    end

    // Read data is the RAM output, or the error code for an out-of-range cell.
    always_comb begin
        disp_data = 2'b00;
        if (disp_rvalid) begin
            disp_data = rvalid_oor_q ? 2'b11 : mem_rdata;
        end
    end

`ifdef BOARD_CLEAR_EN
    // Sweep address counter and the busy/done flags aligned to the RAM write cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt_q <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            clr_busy <= grant_clr;
            clr_done <= (state_q == S_CLEAR) && (clr_cnt_q == NUM_CELLS);
            if (grant_clr) begin
                clr_cnt_q <= clr_cnt_q + 7'd1;
            end else if (state_q != S_CLEAR) begin
                clr_cnt_q <= '0;
            end
        end
    end
`endif

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameter CELLS, default 100: number of board cells (10x10 grid of 32x32-pixel tiles); valid addresses 0..CELLS-1.
REQ-002 Parameter STARVE_LIMIT, default 16: cycles a pending write may be denied before it overrides display reads.
REQ-003 clk  in  1  single clock; every register SHALL update on its rising edge only.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 disp_req  in  1  display pixel path requests a cell read this cycle.
REQ-006 disp_addr  in  7  cell index requested by the display path.
REQ-007 disp_gnt  out  1  registered; display read issued to memory this cycle.
REQ-008 disp_rvalid  out  1  registered; disp_data valid this cycle.
REQ-009 disp_data  out  2  cell code: 00 empty, 01 triangle, 10 circle, 11 error.
REQ-010 wr_req  in  1  game logic write request, held until wr_ack.
REQ-011 wr_addr / wr_data  in  7 / 2  write cell index and code, stable while wr_req is high.
REQ-012 wr_ack  out  1  one-cycle pulse, write completed or discarded.
REQ-013 wr_err  out  1  one-cycle pulse with wr_ack when wr_addr >= CELLS.
REQ-014 mem_addr / mem_we / mem_wdata  out  7 / 1 / 2  registered single-port RAM controls.
REQ-015 mem_rdata  in  2  RAM read data, valid one cycle after mem_addr with mem_we=0.
REQ-016 clr_req / clr_busy / clr_done  in / out / out  1 each  board clear request, sweep active, and one-cycle completion pulse.

Function
REQ-017 The block SHALL grant at most one memory operation per cycle: arbitration in cycle N, mem_* driven in N+1, read data captured in N+2.
REQ-018 Priority per arbitration cycle SHALL be: clear sweep > starved write (starve count == STARVE_LIMIT) > display read > write.
REQ-019 A granted display read SHALL assert disp_gnt in N+1, then disp_rvalid in N+2 with disp_data = mem_rdata; read latency is fixed at 2.
REQ-020 A display read with disp_addr >= CELLS SHALL be granted without a RAM access (mem_we=0) and SHALL return disp_data=11 with normal latency.
REQ-021 A denied display request SHALL produce no disp_gnt and no disp_rvalid; it is not queued.
REQ-022 A granted in-range write SHALL drive mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, and pulse wr_ack for exactly one cycle in N+1.
REQ-023 An out-of-range write SHALL pulse wr_ack and wr_err together, with mem_we held at 0.
REQ-024 No new write SHALL be arbitrated in the cycle its wr_ack is high, preventing a double write of one held request.
REQ-025 The starve counter (5 bits, saturating at STARVE_LIMIT) SHALL increment each arbitration cycle wr_req is high and the write is not granted, and SHALL clear on wr_ack.
REQ-026 States SHALL be IDLE, RUN, and CLEAR.
REQ-027 IDLE -> RUN on the first cycle after reset release.
REQ-028 RUN -> CLEAR on clr_req.
REQ-029 CLEAR -> RUN after address CELLS-1 is written.
REQ-030 CLEAR SHALL write 00 to addresses 0..CELLS-1 at one per cycle, with clr_busy high throughout and clr_done pulsed in the cycle after the last write.
REQ-031 During CLEAR, display reads and writes SHALL be denied, the starve counter SHALL be frozen, and clr_req SHALL be ignored.
REQ-032 When clr_req and wr_req arrive in the same cycle, clear SHALL win and the write SHALL remain pending.
REQ-033 When mem_we=0 and no read is granted, mem_addr SHALL hold its previous value.

Reset
REQ-034 With rst_n low at a clock edge, all outputs SHALL be 0, the state SHALL be IDLE, and the starve and clear counters SHALL be 0.
REQ-035 Reset during CLEAR SHALL abandon the sweep without asserting clr_done.
REQ-036 Reset SHALL discard any in-flight read, so no disp_rvalid follows reset.

Configuration
REQ-037 Macro BOARD_CLEAR_EN SHALL control the clear feature.
REQ-038 With BOARD_CLEAR_EN defined, the CLEAR state and clr_* behaviour SHALL be as specified above.
REQ-039 Without BOARD_CLEAR_EN, the CLEAR state and its counter SHALL be absent, clr_req SHALL be ignored, and clr_busy and clr_done SHALL be tied to 0.

Verification
REQ-040 Display read: disp_req=1, disp_addr=23, RAM[23]=10 -> disp_gnt at +1, disp_rvalid with disp_data=10 at +2.
REQ-041 Write then read: wr_req, wr_addr=5, wr_data=01, disp_req=0 -> one wr_ack, mem_we=1 for one cycle; a later read of 5 returns 01.
REQ-042 Starvation: disp_req held high, wr_req high -> write granted exactly after 16 denied cycles; one display request dropped; counter returns to 0.
REQ-043 Error paths: wr_addr=100 -> wr_ack+wr_err, mem_we stays 0; disp_addr=127 -> disp_data=11 at latency 2.
REQ-044 Clear (BOARD_CLEAR_EN): clr_req with board full of 01 -> clr_busy for 100 cycles, clr_done once, all cells read 00; a write raised mid-sweep is acked only after clr_done.
REQ-045 Reset mid-sweep: rst_n low at address 40 -> outputs 0, no clr_done, IDLE then RUN after release.
